// File: rtl/mips_mode_ctrl.sv
// Run-mode sequencer for the mips32 pipeline: code (imem load) and execute (flush/run/drain/halt).
// Optional RUN watchdog enabled by defining MIPS_MODE_WDOG_EN.
module mips_mode_ctrl #(
  parameter int unsigned AW        = 10,
  parameter int unsigned FLUSH_CYC = 5,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned WDOG_CYC  = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          hlt_id,
  output logic          pipe_en,
  output logic          pipe_flush,
  output logic          busy,
  output logic          done,
  output logic          err_ovf,
  output logic          err_wdog,
  output logic [AW:0]   prog_len,
  output logic [31:0]   cycle_cnt,
  output logic [2:0]    state
);

  localparam int unsigned FW = $clog2(FLUSH_CYC) + 1;
  localparam int unsigned DW = $clog2(DRAIN_CYC) + 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FLUSH  = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     prog_len_d;
  logic            err_ovf_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [31:0]     cycle_cnt_d;
  logic            accept;

`ifdef MIPS_MODE_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0]   wdog_cnt_q, wdog_cnt_d;
  logic            err_wdog_d;
`endif

  // Write port is decoded straight from registered state and pointer.
  assign ld_ready   = (state_q == S_LOAD);
  assign accept     = ld_valid & ld_ready;
  assign imem_we    = accept;
  assign imem_addr  = wr_ptr_q;
  assign imem_wdata = ld_data;
  assign state      = 3'(state_q);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    prog_len_d  = prog_len;
    err_ovf_d   = err_ovf;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    cycle_cnt_d = cycle_cnt;
`ifdef MIPS_MODE_WDOG_EN
    wdog_cnt_d  = wdog_cnt_q;
    err_wdog_d  = err_wdog;
`endif

    case (state_q)
      S_IDLE: begin
        if (!mode) begin
          state_d   = S_LOAD;
          wr_ptr_d  = '0;
          err_ovf_d = 1'b0;
        end else if (start && (prog_len != '0)) begin
          state_d     = S_FLUSH;
          flush_cnt_d = FW'(FLUSH_CYC - 1);
          cycle_cnt_d = '0;
`ifdef MIPS_MODE_WDOG_EN
          wdog_cnt_d  = '0;
          err_wdog_d  = 1'b0;
`endif
        end
      end

      S_LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (ld_last) begin
            prog_len_d = (AW+1)'(wr_ptr_q) + (AW+1)'(1);
            state_d    = S_IDLE;
          end else if (wr_ptr_q == {AW{1'b1}}) begin
            prog_len_d = DEPTH;
            err_ovf_d  = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (mode) begin
          prog_len_d = (AW+1)'(wr_ptr_q);
          state_d    = S_IDLE;
        end
      end

      S_FLUSH: begin
        if (flush_cnt_q == '0) state_d = S_RUN;
        else                   flush_cnt_d = flush_cnt_q - FW'(1);
      end

      S_RUN: begin
        if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt_d = cycle_cnt + 32'd1;
        if (!mode) begin
          state_d = S_IDLE;
        end else if (hlt_id) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DW'(DRAIN_CYC - 1);
        end
`ifdef MIPS_MODE_WDOG_EN
        else if (wdog_cnt_q == WW'(WDOG_CYC - 1)) begin
          state_d    = S_HALTED;
          err_wdog_d = 1'b1;
        end else begin
          wdog_cnt_d = wdog_cnt_q + WW'(1);
        end
`endif
      end

      S_DRAIN: begin
        if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt_d = cycle_cnt + 32'd1;
        if (drain_cnt_q == '0) state_d = S_HALTED;
        else                   drain_cnt_d = drain_cnt_q - DW'(1);
      end

      S_HALTED: begin
        if (!mode) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d     = S_FLUSH;
          flush_cnt_d = FW'(FLUSH_CYC - 1);
          cycle_cnt_d = '0;
`ifdef MIPS_MODE_WDOG_EN
          wdog_cnt_d  = '0;
          err_wdog_d  = 1'b0;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Mode outputs are registered from the next state so they align with state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      prog_len    <= '0;
      err_ovf     <= 1'b0;
      flush_cnt_q <= '0;
      drain_cnt_q <= '0;
      cycle_cnt   <= '0;
      pipe_en     <= 1'b0;
      pipe_flush  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      prog_len    <= prog_len_d;
      err_ovf     <= err_ovf_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt   <= cycle_cnt_d;
      pipe_en     <= (state_d == S_RUN) || (state_d == S_DRAIN);
      pipe_flush  <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_FLUSH);
      busy        <= (state_d != S_IDLE) && (state_d != S_HALTED);
      done        <= (state_d == S_HALTED);
    end
  end

`ifdef MIPS_MODE_WDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q <= '0;
      err_wdog   <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      err_wdog   <= err_wdog_d;
    end
  end
`else
  assign err_wdog = 1'b0;
`endif

endmodule
